// File: rtl/processador_noite_if.sv
// Night-phase bus between the game control unit and the night datapath.
// master: control unit side (drives counter/turn controls, reads results).
// slave : processador_noite side (reads controls, drives targets and victim).
interface processador_noite_if #(
    parameter int N_JOGADORES = 8,
    parameter int W_JOG       = 3
);
    // control unit -> datapath
    logic                   zera_CJ;
    logic                   inc_jogador;
    logic                   processar_acao;
    logic                   passa;
    logic [W_JOG-1:0]       alvo;
    logic [1:0]             classe_atual;
    logic [N_JOGADORES-1:0] vivos;

    // datapath -> control unit
    logic [W_JOG-1:0]       jogador_atual;
    logic                   CJ_fim;
    logic [W_JOG-1:0]       alvo_lobo;
    logic                   alvo_lobo_ok;
    logic [W_JOG-1:0]       alvo_medico;
    logic                   alvo_medico_ok;
    logic [W_JOG-1:0]       alvo_vidente;
    logic                   alvo_vidente_ok;
    logic                   erro_alvo;
    logic                   noite_fim;
    logic [W_JOG-1:0]       morto;
    logic                   morte_ok;

    modport master (
        output zera_CJ, inc_jogador, processar_acao, passa, alvo, classe_atual, vivos,
        input  jogador_atual, CJ_fim, alvo_lobo, alvo_lobo_ok, alvo_medico, alvo_medico_ok,
               alvo_vidente, alvo_vidente_ok, erro_alvo, noite_fim, morto, morte_ok
    );

    modport slave (
        input  zera_CJ, inc_jogador, processar_acao, passa, alvo, classe_atual, vivos,
        output jogador_atual, CJ_fim, alvo_lobo, alvo_lobo_ok, alvo_medico, alvo_medico_ok,
               alvo_vidente, alvo_vidente_ok, erro_alvo, noite_fim, morto, morte_ok
    );
endinterface

// File: rtl/processador_noite.sv
// Night-phase responder: owns the player counter, validates and latches wolf/doctor/seer targets, resolves the victim.
// Latency: accepted confirm visible 1 edge later; last player's confirm -> noite_fim (with morto/morte_ok) 2 edges later.
// Backpressure: none; control inputs are single-cycle pulses, rejects are reported via a one-cycle erro_alvo pulse.
// Ports: clock, reset (async, active-high); bus (slave modport of processador_noite_if) carries the counter
//   controls, the current player's turn/target/role and alive mask in, and the counter, latched targets,
//   erro_alvo, noite_fim and victim out.
module processador_noite #(
    parameter int N_JOGADORES = 8,
    parameter int W_JOG       = 3
) (
    input  logic               clock,
    input  logic               reset,
    processador_noite_if.slave bus
);

    localparam logic [W_JOG-1:0] ULTIMO = W_JOG'(N_JOGADORES - 1);
    localparam logic [W_JOG:0]   N_EXT  = (W_JOG + 1)'(N_JOGADORES);

    typedef enum logic [1:0] {
        AGUARDA = 2'd0,
        RESOLVE = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    estado_t estado, estado_prox;

    logic [W_JOG-1:0]     jogador_atual;
    logic                 acao_feita;
    logic [W_JOG-1:0]     alvo_lobo, alvo_medico, alvo_vidente;
    logic                 alvo_lobo_ok, alvo_medico_ok, alvo_vidente_ok;
    logic                 erro_alvo;
    logic                 noite_fim;
    logic [W_JOG-1:0]     morto;
    logic                 morte_ok;

    logic                 cj_fim;
    logic [2**W_JOG-1:0]  vivos_ext;
    logic                 confirma;
    logic                 alvo_valido;
    logic                 aceita;
    logic                 rejeita;
    logic                 morte;

    // Pad the alive mask to the full index range so out-of-range indices read as dead.
    always_comb begin
        vivos_ext                  = '0;
        vivos_ext[N_JOGADORES-1:0] = bus.vivos;
    end

    assign cj_fim   = (jogador_atual == ULTIMO);
    assign confirma = (estado == AGUARDA) && bus.processar_acao && bus.passa;

    // A wolf may not target itself; other roles may.
    assign alvo_valido = ({1'b0, bus.alvo} < N_EXT)
                      && vivos_ext[bus.alvo]
                      && vivos_ext[jogador_atual]
                      && !((bus.classe_atual == 2'b01) && (bus.alvo == jogador_atual));

    // Once the player has acted, further confirms are silently ignored.
    assign aceita  = confirma && !acao_feita && alvo_valido;
    assign rejeita = confirma && !acao_feita && !alvo_valido;

    // The doctor saves the wolf's victim only when both targets are set and match.
    assign morte = alvo_lobo_ok && !(alvo_medico_ok && (alvo_medico == alvo_lobo));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= AGUARDA;
        end else begin
            estado <= estado_prox;
        end
    end

    // The last player's confirm closes the night even when it is rejected.
    always_comb begin
        estado_prox = estado;
        case (estado)
            AGUARDA: if (confirma && cj_fim) estado_prox = RESOLVE;
            RESOLVE: estado_prox = PRONTO;
            PRONTO:  estado_prox = PRONTO;
            default: estado_prox = AGUARDA;
        endcase
        if (bus.zera_CJ) begin
            estado_prox = AGUARDA;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogador_atual   <= '0;
            acao_feita      <= 1'b0;
            alvo_lobo       <= '0;
            alvo_lobo_ok    <= 1'b0;
            alvo_medico     <= '0;
            alvo_medico_ok  <= 1'b0;
            alvo_vidente    <= '0;
            alvo_vidente_ok <= 1'b0;
            erro_alvo       <= 1'b0;
            noite_fim       <= 1'b0;
            morto           <= '0;
            morte_ok        <= 1'b0;
        end else begin
            erro_alvo <= 1'b0;
            noite_fim <= 1'b0;
            if (bus.zera_CJ) begin
                jogador_atual   <= '0;
                acao_feita      <= 1'b0;
                alvo_lobo       <= '0;
                alvo_lobo_ok    <= 1'b0;
                alvo_medico     <= '0;
                alvo_medico_ok  <= 1'b0;
                alvo_vidente    <= '0;
                alvo_vidente_ok <= 1'b0;
                morto           <= '0;
                morte_ok        <= 1'b0;
            end else begin
                // Advancing to a new player reopens the turn, even if an accept lands on the same edge.
                if (bus.inc_jogador) begin
                    jogador_atual <= cj_fim ? '0 : jogador_atual + 1'b1;
                    acao_feita    <= 1'b0;
                end else if (aceita) begin
                    acao_feita <= 1'b1;
                end

                if (aceita) begin
                    case (bus.classe_atual)
                        2'b01: begin
                            alvo_lobo    <= bus.alvo;
                            alvo_lobo_ok <= 1'b1;
                        end
                        2'b10: begin
                            alvo_medico    <= bus.alvo;
                            alvo_medico_ok <= 1'b1;
                        end
                        2'b11: begin
                            alvo_vidente    <= bus.alvo;
                            alvo_vidente_ok <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                erro_alvo <= rejeita;

                if (estado == RESOLVE) begin
                    morte_ok  <= morte;
                    morto     <= morte ? alvo_lobo : '0;
                    noite_fim <= 1'b1;
                end
            end
        end
    end

    assign bus.jogador_atual   = jogador_atual;
    assign bus.CJ_fim          = cj_fim;
    assign bus.alvo_lobo       = alvo_lobo;
    assign bus.alvo_lobo_ok    = alvo_lobo_ok;
    assign bus.alvo_medico     = alvo_medico;
    assign bus.alvo_medico_ok  = alvo_medico_ok;
    assign bus.alvo_vidente    = alvo_vidente;
    assign bus.alvo_vidente_ok = alvo_vidente_ok;
    assign bus.erro_alvo       = erro_alvo;
    assign bus.noite_fim       = noite_fim;
    assign bus.morto           = morto;
    assign bus.morte_ok        = morte_ok;

endmodule

// File: tb/tb_processador_noite.sv
// Bench for processador_noite with 4 players: night outcomes go through a scoreboard queue,
// per-confirm effects are compared against a small model of the latched targets.
module tb_processador_noite;

    localparam int N = 4;
    localparam int W = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    processador_noite_if #(.N_JOGADORES(N), .W_JOG(W)) bus ();

    processador_noite #(.N_JOGADORES(N), .W_JOG(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         morte_ok;
        logic [W-1:0] morto;
    } res_t;

    res_t fila[$];
    res_t r_mon;

    int total = 0;
    int bad   = 0;

    // model of the latched night state
    logic [W-1:0] m_jog, m_lobo, m_med, m_vid;
    logic         m_lobo_ok, m_med_ok, m_vid_ok, m_feita;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // night results leave the DUT on noite_fim; each pulse cycle must match one queued expectation
    always @(negedge clock) begin
        if (!reset && bus.noite_fim === 1'b1) begin
            if (fila.size() == 0) begin
                verifica("noite_fim_extra", 32'd1, 32'd0);
            end else begin
                r_mon = fila.pop_front();
                verifica("sb_morto", 32'(bus.morto), 32'(r_mon.morto));
                verifica("sb_morte_ok", 32'(bus.morte_ok), 32'(r_mon.morte_ok));
            end
        end
    end

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic modelo_limpa();
        m_jog = '0; m_lobo = '0; m_med = '0; m_vid = '0;
        m_lobo_ok = 1'b0; m_med_ok = 1'b0; m_vid_ok = 1'b0; m_feita = 1'b0;
    endtask

    task automatic confere_alvos(input string tag);
        verifica({tag, "_lobo"}, 32'({bus.alvo_lobo_ok, bus.alvo_lobo}), 32'({m_lobo_ok, m_lobo}));
        verifica({tag, "_med"},  32'({bus.alvo_medico_ok, bus.alvo_medico}), 32'({m_med_ok, m_med}));
        verifica({tag, "_vid"},  32'({bus.alvo_vidente_ok, bus.alvo_vidente}), 32'({m_vid_ok, m_vid}));
    endtask

    // fecha: expect this confirm (from the last player) to produce a night result
    task automatic confirma(input string tag, input logic [1:0] cl, input logic [W-1:0] a,
                            input bit erro_esp, input bit fecha);
        res_t e;
        bus.classe_atual   = cl;
        bus.alvo           = a;
        bus.processar_acao = 1'b1;
        bus.passa          = 1'b1;
        if (!m_feita && !erro_esp) begin
            case (cl)
                2'b01: begin m_lobo = a; m_lobo_ok = 1'b1; end
                2'b10: begin m_med  = a; m_med_ok  = 1'b1; end
                2'b11: begin m_vid  = a; m_vid_ok  = 1'b1; end
                default: ;
            endcase
            m_feita = 1'b1;
        end
        if (fecha && m_jog == W'(N - 1)) begin
            e.morte_ok = m_lobo_ok && !(m_med_ok && m_med == m_lobo);
            e.morto    = e.morte_ok ? m_lobo : '0;
            fila.push_back(e);
        end
        passo();
        bus.passa = 1'b0;
        verifica({tag, "_erro"}, 32'(bus.erro_alvo), 32'(erro_esp));
        confere_alvos(tag);
    endtask

    task automatic avanca(input string tag);
        bus.processar_acao = 1'b0;
        bus.inc_jogador    = 1'b1;
        passo();
        bus.inc_jogador = 1'b0;
        m_jog   = m_jog + 1'b1;
        m_feita = 1'b0;
        verifica({tag, "_jog"}, 32'(bus.jogador_atual), 32'(m_jog));
        verifica({tag, "_cjfim"}, 32'(bus.CJ_fim), 32'(m_jog == W'(N - 1)));
    endtask

    task automatic zera(input string tag);
        bus.processar_acao = 1'b0;
        bus.zera_CJ        = 1'b1;
        passo();
        bus.zera_CJ = 1'b0;
        modelo_limpa();
        verifica({tag, "_jog"}, 32'(bus.jogador_atual), 32'd0);
        verifica({tag, "_morte"}, 32'({bus.morte_ok, bus.morto}), 32'd0);
        confere_alvos(tag);
    endtask

    // noite_fim must appear on the edge after RESOLVE, last exactly one cycle, and drain the queue
    task automatic espera_fim(input string tag);
        passo();
        verifica({tag, "_noite_fim"}, 32'(bus.noite_fim), 32'd1);
        passo();
        verifica({tag, "_noite_fim_pulso"}, 32'(bus.noite_fim), 32'd0);
        verifica({tag, "_fila"}, 32'(fila.size()), 32'd0);
    endtask

    initial begin
        bus.zera_CJ        = 1'b0;
        bus.inc_jogador    = 1'b0;
        bus.processar_acao = 1'b0;
        bus.passa          = 1'b0;
        bus.alvo           = '0;
        bus.classe_atual   = 2'b00;
        bus.vivos          = 4'b1111;
        modelo_limpa();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        verifica("rst_jog", 32'(bus.jogador_atual), 32'd0);
        verifica("rst_cjfim", 32'(bus.CJ_fim), 32'd0);
        verifica("rst_erro", 32'(bus.erro_alvo), 32'd0);
        verifica("rst_noite_fim", 32'(bus.noite_fim), 32'd0);
        verifica("rst_morte", 32'({bus.morte_ok, bus.morto}), 32'd0);
        confere_alvos("rst");
        reset = 1'b0;
        passo();

        // night 1: wolf->2, doctor->3, seer->1, villager -> victim 2
        confirma("n1_lobo", 2'b01, 2'd2, 1'b0, 1'b0);
        avanca("n1_av1");
        confirma("n1_med", 2'b10, 2'd3, 1'b0, 1'b0);
        avanca("n1_av2");
        confirma("n1_vid", 2'b11, 2'd1, 1'b0, 1'b0);
        avanca("n1_av3");
        confirma("n1_ult", 2'b00, 2'd0, 1'b0, 1'b1);
        espera_fim("n1");
        passo();
        verifica("n1_hold", 32'({bus.morte_ok, bus.morto}), 32'({1'b1, 2'd2}));
        // confirms in PRONTO are ignored
        bus.processar_acao = 1'b1;
        bus.passa          = 1'b1;
        passo();
        bus.passa = 1'b0;
        passo();
        verifica("n1_pronto_erro", 32'(bus.erro_alvo), 32'd0);
        verifica("n1_pronto_hold", 32'({bus.morte_ok, bus.morto}), 32'({1'b1, 2'd2}));
        zera("z1");

        // night 2: doctor saves the wolf's target
        confirma("n2_lobo", 2'b01, 2'd2, 1'b0, 1'b0);
        avanca("n2_av1");
        confirma("n2_med", 2'b10, 2'd2, 1'b0, 1'b0);
        avanca("n2_av2");
        confirma("n2_vid", 2'b11, 2'd0, 1'b0, 1'b0);
        avanca("n2_av3");
        confirma("n2_ult", 2'b00, 2'd1, 1'b0, 1'b1);
        espera_fim("n2");
        zera("z2");

        // night 3: player 2 dead; rejects, retries and ignored extra confirms
        bus.vivos = 4'b1011;
        confirma("n3_auto", 2'b01, 2'd0, 1'b1, 1'b0);
        passo();
        verifica("n3_erro_um_ciclo", 32'(bus.erro_alvo), 32'd0);
        confirma("n3_alvo_morto", 2'b01, 2'd2, 1'b1, 1'b0);
        confirma("n3_retry", 2'b01, 2'd3, 1'b0, 1'b0);
        confirma("n3_extra", 2'b01, 2'd1, 1'b0, 1'b0);
        avanca("n3_av1");
        bus.processar_acao = 1'b0;
        bus.passa          = 1'b1;
        bus.classe_atual   = 2'b10;
        bus.alvo           = 2'd0;
        passo();
        bus.passa = 1'b0;
        passo();
        verifica("n3_sem_turno_erro", 32'(bus.erro_alvo), 32'd0);
        confere_alvos("n3_sem_turno");
        confirma("n3_med", 2'b10, 2'd1, 1'b0, 1'b0);
        avanca("n3_av2");
        confirma("n3_jog_morto", 2'b11, 2'd0, 1'b1, 1'b0);
        avanca("n3_av3");
        confirma("n3_ult", 2'b00, 2'd2, 1'b1, 1'b1);
        espera_fim("n3");
        zera("z3");
        bus.vivos = 4'b1111;

        // counter: zera_CJ beats inc_jogador; wrap at N-1
        avanca("c_av1");
        avanca("c_av2");
        bus.inc_jogador = 1'b1;
        bus.zera_CJ     = 1'b1;
        passo();
        bus.inc_jogador = 1'b0;
        bus.zera_CJ     = 1'b0;
        modelo_limpa();
        verifica("c_zera_prio", 32'(bus.jogador_atual), 32'd0);
        avanca("c_av3");
        avanca("c_av4");
        avanca("c_av5");
        avanca("c_wrap");

        // reset while resolving: everything clears at once, no noite_fim
        confirma("r_lobo", 2'b01, 2'd1, 1'b0, 1'b0);
        avanca("r_av1");
        avanca("r_av2");
        avanca("r_av3");
        confirma("r_ult", 2'b00, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        modelo_limpa();
        verifica("r_jog", 32'(bus.jogador_atual), 32'd0);
        verifica("r_cjfim", 32'(bus.CJ_fim), 32'd0);
        verifica("r_noite_fim", 32'(bus.noite_fim), 32'd0);
        verifica("r_morte", 32'({bus.morte_ok, bus.morto}), 32'd0);
        confere_alvos("r");
        bus.processar_acao = 1'b0;
        repeat (2) passo();
        reset = 1'b0;
        repeat (4) passo();
        verifica("r_sem_noite_fim", 32'(bus.noite_fim), 32'd0);

        verifica("fila_final", 32'(fila.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
